// File: rtl/iwdg_service_ctrl.sv
// rtl/iwdg_service_ctrl.sv - Wishbone master that configures and services an IWDG slave
module iwdg_service_ctrl #(
  parameter logic [31:0] BASE_ADR    = 32'h0100_0000,
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter logic [7:0]  POLL_MAX    = 8'd255
) (
  input  logic        clk_m2s,
  input  logic        rst_m2s,
  input  logic        cfg_start,
  input  logic [2:0]  cfg_pr,
  input  logic [11:0] cfg_rlr,
  input  logic        kick,
  output logic        running,
  output logic        busy,
  output logic        kick_done,
  output logic        err,
  output logic [31:0] adr_m2s,
  output logic [15:0] dat_m2s,
  output logic        we_m2s,
  output logic        cyc_m2s,
  output logic        stb_m2s,
  input  logic [15:0] dat_s2m,
  input  logic        ack_s2m
);

  // Register offsets inside the IWDG block
  localparam logic [31:0] KR_OFS = 32'h0;
  localparam logic [31:0] PR_OFS = 32'h4;
  localparam logic [31:0] RL_OFS = 32'h8;
  localparam logic [31:0] ST_OFS = 32'hC;

  // Key register values
  localparam logic [15:0] KEY_UNLOCK = 16'h5555;
  localparam logic [15:0] KEY_START  = 16'hCCCC;
  localparam logic [15:0] KEY_RELOAD = 16'hAAAA;

  // Sequencer states
  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_UNLOCK = 4'd1;
  localparam logic [3:0] ST_WR_PR  = 4'd2;
  localparam logic [3:0] ST_WR_RLR = 4'd3;
  localparam logic [3:0] ST_POLL   = 4'd4;
  localparam logic [3:0] ST_START  = 4'd5;
  localparam logic [3:0] ST_RUN    = 4'd6;
  localparam logic [3:0] ST_KICK   = 4'd7;
  localparam logic [3:0] ST_ERR    = 4'd8;

  // ack_cnt only needs to reach ACK_TIMEOUT-1; the timeout fires on the next stalled cycle
  localparam int ACK_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [ACK_W-1:0] ACK_LAST  = ACK_W'(ACK_TIMEOUT - 1);
  localparam logic [7:0]       POLL_LAST = POLL_MAX - 8'd1;

  logic [3:0]       state;
  logic [2:0]       pr_q;
  logic [11:0]      rlr_q;
  logic             kick_pend;
  logic [ACK_W-1:0] ack_cnt;
  logic [7:0]       poll_cnt;

  logic [31:0]      acc_adr;
  logic [15:0]      acc_dat;
  logic             acc_we;
  logic             st_clear;
  logic             unused_dat;

  // Only the two low status bits (prescale/reload update pending) matter
  assign st_clear   = (dat_s2m[1:0] == 2'b00);
  assign unused_dat = ^dat_s2m[15:2];

  // Address, data and direction of the access owned by the current state
  always_comb begin
    acc_adr = BASE_ADR + KR_OFS;
    acc_dat = 16'h0000;
    acc_we  = 1'b1;
    case (state)
      ST_UNLOCK: acc_dat = KEY_UNLOCK;
      ST_WR_PR: begin
        acc_adr = BASE_ADR + PR_OFS;
        acc_dat = {13'b0, pr_q};
      end
      ST_WR_RLR: begin
        acc_adr = BASE_ADR + RL_OFS;
        acc_dat = {4'b0, rlr_q};
      end
      ST_POLL: begin
        acc_adr = BASE_ADR + ST_OFS;
        acc_we  = 1'b0;
      end
      ST_START:  acc_dat = KEY_START;
      ST_KICK:   acc_dat = KEY_RELOAD;
      default:   acc_dat = 16'h0000;
    endcase
  end

  // Sequencer, bus master and status outputs; every output is a flop
  always_ff @(posedge clk_m2s) begin
    if (rst_m2s) begin
      state     <= ST_IDLE;
      pr_q      <= 3'd0;
      rlr_q     <= 12'd0;
      kick_pend <= 1'b0;
      ack_cnt   <= '0;
      poll_cnt  <= 8'd0;
      running   <= 1'b0;
      busy      <= 1'b0;
      kick_done <= 1'b0;
      err       <= 1'b0;
      adr_m2s   <= 32'd0;
      dat_m2s   <= 16'd0;
      we_m2s    <= 1'b0;
      cyc_m2s   <= 1'b0;
      stb_m2s   <= 1'b0;
    end else begin
      kick_done <= 1'b0;

      // A kick that arrives while a key write is in flight is remembered once
      if (kick && (state == ST_KICK || state == ST_START)) begin
        kick_pend <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (cfg_start) begin
            pr_q  <= cfg_pr;
            rlr_q <= cfg_rlr;
            busy  <= 1'b1;
            state <= ST_UNLOCK;
          end
        end

        ST_RUN: begin
          if (cfg_start) begin
            pr_q      <= cfg_pr;
            rlr_q     <= cfg_rlr;
            busy      <= 1'b1;
            running   <= 1'b0;
            kick_pend <= 1'b0;
            state     <= ST_UNLOCK;
          end else if (kick || kick_pend) begin
            busy      <= 1'b1;
            kick_pend <= 1'b0;
            state     <= ST_KICK;
          end
        end

        ST_ERR: begin
          if (cfg_start) begin
            pr_q  <= cfg_pr;
            rlr_q <= cfg_rlr;
            err   <= 1'b0;
            busy  <= 1'b1;
            state <= ST_UNLOCK;
          end
        end

        default: begin
          if (!cyc_m2s) begin
            // Launch this state's access; cyc was low for at least the previous cycle
            cyc_m2s <= 1'b1;
            stb_m2s <= 1'b1;
            adr_m2s <= acc_adr;
            dat_m2s <= acc_dat;
            we_m2s  <= acc_we;
            ack_cnt <= '0;
          end else if (ack_s2m) begin
            cyc_m2s <= 1'b0;
            stb_m2s <= 1'b0;
            adr_m2s <= 32'd0;
            dat_m2s <= 16'd0;
            we_m2s  <= 1'b0;
            case (state)
              ST_UNLOCK: state <= ST_WR_PR;
              ST_WR_PR:  state <= ST_WR_RLR;
              ST_WR_RLR: begin
                poll_cnt <= 8'd0;
                state    <= ST_POLL;
              end
              ST_POLL: begin
                if (st_clear) begin
                  state <= ST_START;
                end else if (poll_cnt == POLL_LAST) begin
                  err       <= 1'b1;
                  busy      <= 1'b0;
                  running   <= 1'b0;
                  kick_pend <= 1'b0;
                  state     <= ST_ERR;
                end else begin
                  poll_cnt <= poll_cnt + 8'd1;
                end
              end
              ST_START: begin
                running <= 1'b1;
                busy    <= 1'b0;
                state   <= ST_RUN;
              end
              ST_KICK: begin
                kick_done <= 1'b1;
                busy      <= 1'b0;
                state     <= ST_RUN;
              end
              default: state <= ST_IDLE;
            endcase
          end else if (ack_cnt == ACK_LAST) begin
            // Slave stalled too long: abandon the access and park in ERR
            cyc_m2s   <= 1'b0;
            stb_m2s   <= 1'b0;
            adr_m2s   <= 32'd0;
            dat_m2s   <= 16'd0;
            we_m2s    <= 1'b0;
            err       <= 1'b1;
            busy      <= 1'b0;
            running   <= 1'b0;
            kick_pend <= 1'b0;
            state     <= ST_ERR;
          end else begin
            ack_cnt <= ack_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iwdg_service_ctrl.sv
// tb/tb_iwdg_service_ctrl.sv - scoreboard bench for iwdg_service_ctrl
module tb_iwdg_service_ctrl;

  localparam logic [31:0] BASE   = 32'h0100_0000;
  localparam logic [31:0] NO_ADR = 32'hFFFF_FFFF;

  logic        clk_m2s = 1'b0;
  logic        rst_m2s;
  logic        cfg_start;
  logic [2:0]  cfg_pr;
  logic [11:0] cfg_rlr;
  logic        kick;
  logic        running;
  logic        busy;
  logic        kick_done;
  logic        err;
  logic [31:0] adr_m2s;
  logic [15:0] dat_m2s;
  logic        we_m2s;
  logic        cyc_m2s;
  logic        stb_m2s;
  logic [15:0] dat_s2m = 16'd0;
  logic        ack_s2m = 1'b0;

  always #5 clk_m2s = ~clk_m2s;

  iwdg_service_ctrl dut (
    .clk_m2s  (clk_m2s),
    .rst_m2s  (rst_m2s),
    .cfg_start(cfg_start),
    .cfg_pr   (cfg_pr),
    .cfg_rlr  (cfg_rlr),
    .kick     (kick),
    .running  (running),
    .busy     (busy),
    .kick_done(kick_done),
    .err      (err),
    .adr_m2s  (adr_m2s),
    .dat_m2s  (dat_m2s),
    .we_m2s   (we_m2s),
    .cyc_m2s  (cyc_m2s),
    .stb_m2s  (stb_m2s),
    .dat_s2m  (dat_s2m),
    .ack_s2m  (ack_s2m)
  );

  int          errors = 0;
  int          checks = 0;
  logic [48:0] exp_q[$];
  logic [15:0] st_q[$];
  int          fixed_lat = -1;
  logic [31:0] mute_adr = NO_ADR;
  int          last_hi_len = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [48:0] wr(input logic [31:0] a, input logic [15:0] d);
    return {1'b1, a, d};
  endfunction

  function automatic logic [48:0] rd(input logic [31:0] a);
    return {1'b0, a, 16'h0000};
  endfunction

  // Reference model: the bus transactions a (re)configuration must produce
  task automatic expect_config(input logic [2:0] pr, input logic [11:0] rlr,
                               input int n_busy, input bit ok);
    logic [15:0] v;
    exp_q.push_back(wr(BASE, 16'h5555));
    exp_q.push_back(wr(BASE + 32'h4, {13'b0, pr}));
    exp_q.push_back(wr(BASE + 32'h8, {4'b0, rlr}));
    for (int i = 0; i < n_busy; i++) begin
      v = 16'($urandom);
      if (v[1:0] == 2'b00) v[1:0] = 2'b01;
      st_q.push_back(v);
      exp_q.push_back(rd(BASE + 32'hC));
    end
    if (ok) begin
      v = 16'($urandom) & 16'hFFFC;
      st_q.push_back(v);
      exp_q.push_back(rd(BASE + 32'hC));
      exp_q.push_back(wr(BASE, 16'hCCCC));
    end
  endtask

  // Slave model and monitor: acks, checks protocol, pops the scoreboard
  logic        kd_expect = 1'b0;
  int          hi_len = 0;
  int          lat = 0;
  logic [48:0] held;
  logic [48:0] obs;
  always @(negedge clk_m2s) begin
    if (rst_m2s) begin
      ack_s2m   = 1'b0;
      dat_s2m   = 16'd0;
      hi_len    = 0;
      kd_expect = 1'b0;
    end else if (ack_s2m) begin
      ack_s2m = 1'b0;
      chk("gap_after_ack", cyc_m2s, 0);
      chk("kick_done_on_ack", kick_done, kd_expect);
      kd_expect = 1'b0;
      hi_len    = 0;
    end else begin
      chk("kick_done_quiet", kick_done, 0);
      chk("stb_eq_cyc", stb_m2s, cyc_m2s);
      if (cyc_m2s) begin
        if (hi_len == 0) begin
          held = {we_m2s, adr_m2s, dat_m2s};
          lat  = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
        end else begin
          chk("hold_stable", {we_m2s, adr_m2s, dat_m2s}, held);
        end
        hi_len++;
        if (adr_m2s != mute_adr && hi_len > lat) begin
          obs = we_m2s ? {1'b1, adr_m2s, dat_m2s} : {1'b0, adr_m2s, 16'h0000};
          if (!we_m2s) begin
            if (st_q.size() > 0) dat_s2m = st_q.pop_front();
            else dat_s2m = 16'($urandom) & 16'hFFFC;
          end
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_access: got %0h expected none", obs);
          end else begin
            chk("bus_access", obs, exp_q.pop_front());
          end
          kd_expect = (obs == wr(BASE, 16'hAAAA));
          ack_s2m   = 1'b1;
        end
      end else begin
        if (hi_len > 0) last_hi_len = hi_len;
        hi_len = 0;
      end
    end
  end

  task automatic pulse_cfg(input logic [2:0] pr, input logic [11:0] rlr, input bit with_kick);
    cfg_pr    = pr;
    cfg_rlr   = rlr;
    cfg_start = 1'b1;
    kick      = with_kick;
    @(negedge clk_m2s);
    cfg_start = 1'b0;
    kick      = 1'b0;
    cfg_pr    = 3'($urandom);
    cfg_rlr   = 12'($urandom);
  endtask

  task automatic pulse_kick();
    kick = 1'b1;
    @(negedge clk_m2s);
    kick = 1'b0;
  endtask

  task automatic wait_run(input string name, input int budget);
    int n;
    n = 0;
    while (!(running && !busy && exp_q.size() == 0) && n < budget) begin
      @(negedge clk_m2s);
      n++;
    end
    chk({name, "_reached_run"}, (n < budget), 1);
    chk({name, "_err_low"}, err, 0);
  endtask

  task automatic wait_err(input string name, input int budget);
    int n;
    n = 0;
    while (!err && n < budget) begin
      @(negedge clk_m2s);
      n++;
    end
    chk({name, "_err_set"}, err, 1);
    @(negedge clk_m2s);
  endtask

  task automatic wait_bus(input string name, input logic [31:0] a, input logic [15:0] d,
                          input bit use_d, input int budget);
    int n;
    n = 0;
    while (!(cyc_m2s && adr_m2s == a && (!use_d || dat_m2s == d)) && n < budget) begin
      @(negedge clk_m2s);
      n++;
    end
    chk({name, "_seen"}, (n < budget), 1);
  endtask

  logic [2:0]  rpr;
  logic [11:0] rrlr;

  initial begin
    rst_m2s   = 1'b1;
    cfg_start = 1'b0;
    cfg_pr    = 3'd0;
    cfg_rlr   = 12'd0;
    kick      = 1'b0;
    repeat (3) @(negedge clk_m2s);
    chk("rst_running", running, 0);
    chk("rst_busy", busy, 0);
    chk("rst_kick_done", kick_done, 0);
    chk("rst_err", err, 0);
    chk("rst_bus", {cyc_m2s, stb_m2s, we_m2s, adr_m2s, dat_m2s}, 0);
    rst_m2s = 1'b0;
    @(negedge clk_m2s);

    // Kick while IDLE is dropped
    pulse_kick();
    repeat (3) @(negedge clk_m2s);
    chk("idle_kick_busy", busy, 0);

    // Basic configuration with an immediate-ack slave and clear status
    fixed_lat = 0;
    expect_config(3'd2, 12'h123, 0, 1);
    pulse_cfg(3'd2, 12'h123, 1'b0);
    wait_run("cfg_basic", 60);

    // Single kick
    exp_q.push_back(wr(BASE, 16'hAAAA));
    pulse_kick();
    wait_run("kick_single", 30);

    // Random kicks with random slave latency
    fixed_lat = -1;
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk_m2s);
      exp_q.push_back(wr(BASE, 16'hAAAA));
      pulse_kick();
      wait_run("kick_rand", 40);
    end

    // Three kicks during an in-flight KICK merge into one more reload write
    fixed_lat = 6;
    exp_q.push_back(wr(BASE, 16'hAAAA));
    exp_q.push_back(wr(BASE, 16'hAAAA));
    pulse_kick();
    wait_bus("merge_kick", BASE, 16'hAAAA, 1'b1, 10);
    pulse_kick();
    @(negedge clk_m2s);
    pulse_kick();
    @(negedge clk_m2s);
    pulse_kick();
    wait_run("kick_merge", 60);

    // Status busy twice before clearing
    fixed_lat = -1;
    rpr  = 3'($urandom);
    rrlr = 12'($urandom);
    expect_config(rpr, rrlr, 2, 1);
    pulse_cfg(rpr, rrlr, 1'b0);
    wait_run("cfg_poll2", 100);

    // Kicks during config dropped, cfg_start while busy ignored, kick during START kept
    fixed_lat = 3;
    rpr  = 3'($urandom);
    rrlr = 12'($urandom);
    expect_config(rpr, rrlr, 1, 1);
    exp_q.push_back(wr(BASE, 16'hAAAA));
    pulse_cfg(rpr, rrlr, 1'b0);
    wait_bus("cfg_pr_phase", BASE + 32'h4, 16'h0, 1'b0, 20);
    pulse_kick();
    pulse_cfg(~rpr, ~rrlr, 1'b0);
    wait_bus("cfg_poll_phase", BASE + 32'hC, 16'h0, 1'b0, 30);
    pulse_kick();
    wait_bus("cfg_start_phase", BASE, 16'hCCCC, 1'b1, 40);
    pulse_kick();
    wait_run("cfg_kicks", 60);

    // cfg_start and kick together in RUN: reconfigure, kick dropped
    fixed_lat = -1;
    rpr  = 3'($urandom);
    rrlr = 12'($urandom);
    expect_config(rpr, rrlr, 0, 1);
    pulse_cfg(rpr, rrlr, 1'b1);
    wait_run("cfg_and_kick", 80);

    // Slave never acks the unlock write
    mute_adr = BASE;
    pulse_cfg(3'($urandom), 12'($urandom), 1'b0);
    wait_err("timeout", 60);
    chk("timeout_running", running, 0);
    chk("timeout_busy", busy, 0);
    chk("timeout_cyc", cyc_m2s, 0);
    chk("timeout_cyc_len", last_hi_len, 16);
    pulse_kick();
    repeat (3) @(negedge clk_m2s);
    chk("err_sticky", err, 1);

    // Recovery from ERR
    mute_adr = NO_ADR;
    rpr  = 3'($urandom);
    rrlr = 12'($urandom);
    expect_config(rpr, rrlr, 1, 1);
    pulse_cfg(rpr, rrlr, 1'b0);
    chk("err_cleared", err, 0);
    wait_run("recover", 80);

    // Poll limit: every one of POLL_MAX reads reports busy
    fixed_lat = 0;
    rpr  = 3'($urandom);
    rrlr = 12'($urandom);
    expect_config(rpr, rrlr, 255, 0);
    pulse_cfg(rpr, rrlr, 1'b0);
    wait_err("poll_limit", 2000);
    chk("poll_limit_running", running, 0);
    chk("poll_limit_drained", exp_q.size(), 0);

    // One read short of the limit still succeeds
    rpr  = 3'($urandom);
    rrlr = 12'($urandom);
    expect_config(rpr, rrlr, 254, 1);
    pulse_cfg(rpr, rrlr, 1'b0);
    wait_run("poll_254", 2000);

    // Reset in the middle of the reload-value write
    mute_adr = BASE + 32'h8;
    rpr  = 3'($urandom);
    rrlr = 12'($urandom);
    exp_q.push_back(wr(BASE, 16'h5555));
    exp_q.push_back(wr(BASE + 32'h4, {13'b0, rpr}));
    pulse_cfg(rpr, rrlr, 1'b0);
    wait_bus("rlr_phase", BASE + 32'h8, {4'b0, rrlr}, 1'b1, 20);
    rst_m2s = 1'b1;
    @(negedge clk_m2s);
    chk("midrst_bus", {cyc_m2s, stb_m2s, we_m2s, adr_m2s, dat_m2s}, 0);
    chk("midrst_flags", {running, busy, kick_done, err}, 0);
    chk("midrst_drained", exp_q.size(), 0);
    rst_m2s  = 1'b0;
    mute_adr = NO_ADR;
    @(negedge clk_m2s);

    // Back to service after reset
    fixed_lat = -1;
    rpr  = 3'($urandom);
    rrlr = 12'($urandom);
    expect_config(rpr, rrlr, 1, 1);
    pulse_cfg(rpr, rrlr, 1'b0);
    wait_run("post_reset", 80);
    exp_q.push_back(wr(BASE, 16'hAAAA));
    pulse_kick();
    wait_run("post_reset_kick", 30);

    repeat (3) @(negedge clk_m2s);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
